// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Fetch-to-decode valid/ready queue carrying PC, instruction and
//               BTB prediction; registered storage, no fall-through, flushable.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
  parameter int                 CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [PC_W-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_pc_sel_BTB,
  input  logic [PC_W-1:0]    i_predict_pc,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PC_W-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_pc_sel_BTB,
  output logic [PC_W-1:0]    o_predict_pc,
  output logic [CNT_W-1:0]   o_count
);

  localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   c_full_cnt = CNT_W'(DEPTH);

  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic               r_sel_mem   [DEPTH];
  logic [PC_W-1:0]    r_ppc_mem   [DEPTH];

  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [c_ptr_w-1:0] w_head_nxt;
  logic [c_ptr_w-1:0] w_tail_nxt;

  assign o_ready = (r_count < c_full_cnt);
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  // Flush suppresses both handshakes; readiness is judged on the pre-pop count.
  assign w_push = i_valid & o_ready & ~i_flush;
  assign w_pop  = o_valid & i_ready & ~i_flush;

  // Explicit compare keeps wrap correct for non-power-of-two depths.
  assign w_head_nxt = (r_head == c_last_ptr) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == c_last_ptr) ? '0 : r_tail + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= w_tail_nxt;
      if (w_pop)  r_head <= w_head_nxt;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is intentionally unreset; occupancy alone defines validity.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push) begin
      r_pc_mem[r_tail]    <= i_pc;
      r_instr_mem[r_tail] <= i_instr;
      r_sel_mem[r_tail]   <= i_pc_sel_BTB;
      r_ppc_mem[r_tail]   <= i_predict_pc;
    end
  end

  assign o_pc         = o_valid ? r_pc_mem[r_head]    : '0;
  assign o_instr      = o_valid ? r_instr_mem[r_head] : NOP_INSTR;
  assign o_pc_sel_BTB = o_valid ? r_sel_mem[r_head]   : 1'b0;
  assign o_predict_pc = o_valid ? r_ppc_mem[r_head]   : '0;

endmodule
`default_nettype wire
